mole_game_engine: RTL

MOLE_GAME_ENGINE -- requirements
Module: mole_game_engine

---
 rtl/mole_game_engine.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mole_game_engine.sv
// Whack-a-mole game engine: ms/second timebase, mole up/down windows, hit/miss
// scoring with combo and level progression, and a high-score register.
module mole_game_engine #(
  parameter int NUM_HOLES           = 18,
  parameter int CLKS_PER_MS         = 50000,
  parameter int GAME_LENGTH_SECONDS = 20,
  parameter int MOLE_UP_MS_START    = 1000,
  parameter int MOLE_UP_MS_MIN      = 250,
  parameter int MOLE_UP_STEP_MS     = 150,
  parameter int MOLE_DOWN_MS        = 500,
  parameter int NUM_LEVELS          = 4,
  parameter int LEVEL_UP_HITS       = 10,
  parameter int MAX_COMBO           = 99,
  parameter int MAX_SCORE           = 9999,
  localparam int SEC_W = $clog2(GAME_LENGTH_SECONDS + 1),
  localparam int LVL_W = $clog2(NUM_LEVELS + 1),
  localparam int CMB_W = $clog2(MAX_COMBO + 1),
  localparam int SCR_W = $clog2(MAX_SCORE + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_HOLES-1:0] whack,
  input  logic [NUM_HOLES-1:0] mole_pattern,
  output logic                 mole_req,
  output logic [NUM_HOLES-1:0] moles,
  output logic                 game_in_progress,
  output logic                 game_over,
  output logic [SEC_W-1:0]     seconds_left,
  output logic [LVL_W-1:0]     level,
  output logic [CMB_W-1:0]     combo,
  output logic [SCR_W-1:0]     score,
  output logic [SCR_W-1:0]     high_score,
  output logic [1:0]           state_dbg
);

  localparam int MS_W  = $clog2(CLKS_PER_MS + 1);
  localparam int PH_W  = 16;
  localparam int HIT_W = $clog2(LEVEL_UP_HITS + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOLE_DOWN = 2'd1,
    MOLE_UP   = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  state_t               state;
  logic [MS_W-1:0]      ms_cnt;
  logic [9:0]           sec_cnt;
  logic [PH_W-1:0]      phase_ms;
  logic [HIT_W-1:0]     lvl_hits;

  logic                 active, tick, pre_tick, last_second;
  logic                 hit, miss, full_clear, up_done;
  logic [NUM_HOLES-1:0] left_bits, load_bits;
  logic [CMB_W-1:0]     combo_nxt;
  logic [SCR_W-1:0]     score_nxt;
  int                   up_ms, combo_sum, score_sum;

  assign game_in_progress = active;
  assign game_over        = (state == GAME_OVER);
  assign state_dbg        = state;

  always_comb begin
    active      = (state == MOLE_DOWN) || (state == MOLE_UP);
    tick        = active && (ms_cnt == MS_W'(CLKS_PER_MS - 1));
    // One cycle ahead of a tick, so the registered mole_req lands on the last cycle.
    pre_tick    = active && ((CLKS_PER_MS == 1) ? 1'b1 : (ms_cnt == MS_W'(CLKS_PER_MS - 2)));
    last_second = tick && (sec_cnt == 10'd999) && (seconds_left == SEC_W'(1));
    left_bits   = moles & ~whack;
    hit         = (state == MOLE_UP) && ((whack & moles) != '0);
    miss        = (state == MOLE_UP) && ((whack & ~moles) != '0);
    full_clear  = hit && !miss && (left_bits == '0);
    load_bits   = (mole_pattern == '0) ? NUM_HOLES'(1) : mole_pattern;
    up_ms       = MOLE_UP_MS_START - (int'(level) - 1) * MOLE_UP_STEP_MS;
    if (up_ms < MOLE_UP_MS_MIN) up_ms = MOLE_UP_MS_MIN;
    up_done     = tick && (int'(phase_ms) == up_ms - 1);
    combo_sum   = int'(combo) + (full_clear ? 2 : 1);
    if (combo_sum > MAX_COMBO) combo_sum = MAX_COMBO;
    score_sum   = int'(score) + combo_sum;
    if (score_sum > MAX_SCORE) score_sum = MAX_SCORE;
    combo_nxt   = CMB_W'(combo_sum);
    score_nxt   = SCR_W'(score_sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ms_cnt       <= '0;
      sec_cnt      <= '0;
      phase_ms     <= '0;
      lvl_hits     <= '0;
      mole_req     <= 1'b0;
      moles        <= '0;
      seconds_left <= '0;
      level        <= '0;
      combo        <= '0;
      score        <= '0;
      high_score   <= '0;
    end else begin
      mole_req <= 1'b0;
      if (active) begin
        ms_cnt <= tick ? '0 : ms_cnt + 1'b1;
        if (tick) begin
          sec_cnt <= (sec_cnt == 10'd999) ? '0 : sec_cnt + 1'b1;
          if (sec_cnt == 10'd999) seconds_left <= seconds_left - 1'b1;
        end
      end

      case (state)
        IDLE, GAME_OVER: begin
          if (start) begin
            state        <= MOLE_DOWN;
            ms_cnt       <= '0;
            sec_cnt      <= '0;
            phase_ms     <= '0;
            lvl_hits     <= '0;
            moles        <= '0;
            seconds_left <= SEC_W'(GAME_LENGTH_SECONDS);
            level        <= LVL_W'(1);
            combo        <= '0;
            score        <= '0;
          end
        end
        MOLE_DOWN: begin
          if (mole_req) begin
            moles    <= load_bits;
            state    <= MOLE_UP;
            phase_ms <= '0;
          end else begin
            if (tick) phase_ms <= phase_ms + 1'b1;
            if (pre_tick && (phase_ms == PH_W'(MOLE_DOWN_MS - 1))) mole_req <= 1'b1;
          end
        end
        MOLE_UP: begin
          moles <= left_bits;
          if (miss) begin
            combo <= '0;
          end else if (hit) begin
            combo <= combo_nxt;
            score <= score_nxt;
            if (lvl_hits == HIT_W'(LEVEL_UP_HITS - 1)) begin
              lvl_hits <= '0;
              if (level < LVL_W'(NUM_LEVELS)) level <= level + 1'b1;
            end else begin
              lvl_hits <= lvl_hits + 1'b1;
            end
          end
          if (left_bits == '0) begin
            state    <= MOLE_DOWN;
            phase_ms <= '0;
          end else if (up_done) begin
            state    <= MOLE_DOWN;
            phase_ms <= '0;
            moles    <= '0;
            combo    <= '0;
          end else if (tick) begin
            phase_ms <= phase_ms + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // End of game overrides any activity in the final cycle.
      if (last_second) begin
        state    <= GAME_OVER;
        moles    <= '0;
        mole_req <= 1'b0;
        combo    <= combo;
        score    <= score;
        level    <= level;
        lvl_hits <= lvl_hits;
        phase_ms <= '0;
        ms_cnt   <= '0;
        sec_cnt  <= '0;
        if (score > high_score) high_score <= score;
      end
    end
  end

endmodule
